// File: rtl/cheat_loader.sv
// cheat_loader
//
// Byte-stream front end for the cheat-code table. Accepts command/record
// bytes on a valid/ready stream, assembles each 16-byte record into the
// 129-bit word consumed by the cheat-code matcher, and raises the record's
// clock bit (code[128]) for a fixed number of cycles. Also generates the
// matcher's table-clear pulse.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   in_valid     upstream byte valid
//   in_data      upstream byte payload
//   in_ready     byte accepted on a rising edge when in_valid && in_ready
//   code         {clock bit, flags, address, compare, replace}
//   codes_clear  active-high clear strobe for the matcher table
//   busy         high whenever the loader is not idle
//   err_timeout  sticky: a partial record was aborted after going idle too long
//   err_cmd      one-cycle pulse: an unknown command byte arrived while idle
//   load_count   records strobed since the last clear (wraps at 255)

module cheat_loader #(
   parameter int STROBE_CYCLES  = 2,
   parameter int GAP_CYCLES     = 2,
   parameter int CLEAR_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic [128:0] code,
   output logic         codes_clear,
   output logic         busy,
   output logic         err_timeout,
   output logic         err_cmd,
   output logic [7:0]   load_count
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_STROBE  = 3'd2;
   localparam logic [2:0] ST_CLEAR   = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   localparam logic [7:0] CMD_RECORD = 8'h01;
   localparam logic [7:0] CMD_CLEAR  = 8'h02;

   logic [2:0]   state;
   logic         started;
   // Only the 15 most recent bytes can ever reach code[127:8], so older
   // shifted-out bytes are not kept.
   logic [119:0] shreg;
   logic [3:0]   byte_cnt;
   logic [31:0]  phase_cnt;
   logic [31:0]  idle_cnt;
   logic         accept;

   // started holds in_ready low until the first edge after reset release
   assign in_ready = started && (state == ST_IDLE || state == ST_COLLECT);
   assign busy     = (state != ST_IDLE);
   assign accept   = in_valid && in_ready;

   // Main sequencer: command decode, record assembly, strobe/clear timing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         started     <= 1'b0;
         shreg       <= '0;
         byte_cnt    <= '0;
         phase_cnt   <= '0;
         idle_cnt    <= '0;
         code        <= '0;
         codes_clear <= 1'b0;
         err_timeout <= 1'b0;
         err_cmd     <= 1'b0;
         load_count  <= '0;
      end else begin
         started <= 1'b1;
         err_cmd <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (in_data == CMD_RECORD) begin
                     state       <= ST_COLLECT;
                     byte_cnt    <= '0;
                     idle_cnt    <= '0;
                     shreg       <= '0;
                     err_timeout <= 1'b0;
                  end else if (in_data == CMD_CLEAR) begin
                     state       <= ST_CLEAR;
                     phase_cnt   <= '0;
                     codes_clear <= 1'b1;
                     load_count  <= '0;
                     err_timeout <= 1'b0;
                  end else begin
                     err_cmd <= 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               // An accepted byte wins over a timeout landing on the same edge
               if (accept) begin
                  idle_cnt <= '0;
                  byte_cnt <= byte_cnt + 4'd1;
                  if (byte_cnt == 4'd15) begin
                     code      <= {1'b1, shreg, in_data};
                     state     <= ST_STROBE;
                     phase_cnt <= '0;
                  end else begin
                     shreg <= {shreg[111:0], in_data};
                  end
               end else if (TIMEOUT_CYCLES != 0 &&
                            idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  state       <= ST_IDLE;
                  err_timeout <= 1'b1;
                  shreg       <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 32'd1;
               end
            end
            ST_STROBE: begin
               if (phase_cnt == 32'(STROBE_CYCLES - 1)) begin
                  code[128]  <= 1'b0;
                  load_count <= load_count + 8'd1;
                  state      <= ST_GAP;
                  phase_cnt  <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 32'd1;
               end
            end
            ST_CLEAR: begin
               if (phase_cnt == 32'(CLEAR_CYCLES - 1)) begin
                  codes_clear <= 1'b0;
                  state       <= ST_GAP;
                  phase_cnt   <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 32'd1;
               end
            end
            ST_GAP: begin
               if (phase_cnt == 32'(GAP_CYCLES - 1)) begin
                  state     <= ST_IDLE;
                  phase_cnt <= '0;
               end else begin
                  phase_cnt <= phase_cnt + 32'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
